// File: rtl/decode_issue_stage.sv
// Decode/issue stage: MIPS-subset decode, busy-scoreboard hazard stall,
// and a 1-entry ID/EX output register with valid/ready handshake.
module decode_issue_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   output logic [4:0]       rf_read1,
   output logic [4:0]       rf_read2,
   input  logic [31:0]      rf_data1,
   input  logic [31:0]      rf_data2,
   input  logic             wb_valid,
   input  logic [4:0]       wb_reg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_rs_val,
   output logic [31:0]      out_rt_val,
   output logic [31:0]      out_imm,
   output logic [4:0]       out_dest,
   output logic             out_regwrite,
   output logic [5:0]       out_alu_op,
   output logic             out_illegal,
   output logic [31:0]      out_pc,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic        regwrite;
      logic [5:0]  alu_op;
      logic        illegal;
      logic [31:0] pc;
   } id_ex_t;

   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;
   logic        is_r, is_i, is_sb, zext;
   logic        use_rs, use_rt, regwrite, illegal;
   logic [4:0]  dest;
   logic        hazard, fire;
   logic [31:0] busy, busy_nxt;
   id_ex_t      id_ex, id_ex_nxt;
   logic        unused_shamt;

   assign op       = in_instr[31:26];
   assign rs       = in_instr[25:21];
   assign rt       = in_instr[20:16];
   assign rd       = in_instr[15:11];
   assign rf_read1 = rs;
   assign rf_read2 = rt;

   assign unused_shamt = ^in_instr[10:6];

   assign is_r  = (op == 6'h00);
   assign is_i  = op inside {6'h08, 6'h09, 6'h0c, 6'h0d, 6'h23};
   assign is_sb = op inside {6'h2b, 6'h04};
   assign zext  = op inside {6'h0c, 6'h0d};

   always_comb begin
      dest     = 5'd0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      unique case (1'b1)
         is_r: begin
            dest     = rd;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
            regwrite = (rd != 5'd0);
         end
         is_i: begin
            dest     = rt;
            use_rs   = 1'b1;
            regwrite = (rt != 5'd0);
         end
         is_sb: begin
            use_rs   = 1'b1;
            use_rt   = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   // No writeback bypass: busy is the registered state only.
   assign hazard = in_valid &&
                   ((use_rs && busy[rs]) ||
                    (use_rt && busy[rt]) ||
                    (regwrite && busy[dest]));

   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign fire     = in_valid && in_ready;

   // Clear first so an issue to the same register wins.
   always_comb begin
      busy_nxt = busy;
      if (wb_valid)
         busy_nxt[wb_reg] = 1'b0;
      if (fire && regwrite)
         busy_nxt[dest] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      id_ex_nxt.rs_val   = rf_data1;
      id_ex_nxt.rt_val   = rf_data2;
      id_ex_nxt.imm      = zext ? {16'h0000, in_instr[15:0]}
                                : {{16{in_instr[15]}}, in_instr[15:0]};
      id_ex_nxt.dest     = dest;
      id_ex_nxt.regwrite = regwrite;
      id_ex_nxt.alu_op   = is_r ? in_instr[5:0] : op;
      id_ex_nxt.illegal  = illegal;
      id_ex_nxt.pc       = in_pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= '0;
         out_valid <= 1'b0;
         id_ex     <= '0;
         stall_cnt <= '0;
      end else begin
         busy <= busy_nxt;
         if (fire) begin
            out_valid <= 1'b1;
            id_ex     <= id_ex_nxt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (hazard && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign out_rs_val   = id_ex.rs_val;
   assign out_rt_val   = id_ex.rt_val;
   assign out_imm      = id_ex.imm;
   assign out_dest     = id_ex.dest;
   assign out_regwrite = id_ex.regwrite;
   assign out_alu_op   = id_ex.alu_op;
   assign out_illegal  = id_ex.illegal;
   assign out_pc       = id_ex.pc;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed scenarios then
// random traffic against a set-based hazard model.
module tb_decode_issue_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic [4:0]  rf_read1, rf_read2;
   logic [31:0] rf_data1, rf_data2;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_rs_val, out_rt_val, out_imm, out_pc;
   logic [4:0]  out_dest;
   logic        out_regwrite, out_illegal;
   logic [5:0]  out_alu_op;
   logic [15:0] stall_cnt;

   decode_issue_stage #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .rf_read1(rf_read1), .rf_read2(rf_read2),
      .rf_data1(rf_data1), .rf_data2(rf_data2),
      .wb_valid(wb_valid), .wb_reg(wb_reg),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
      .out_imm(out_imm), .out_dest(out_dest),
      .out_regwrite(out_regwrite), .out_alu_op(out_alu_op),
      .out_illegal(out_illegal), .out_pc(out_pc),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   logic [31:0] rf [32];
   always_comb begin
      rf_data1 = rf[rf_read1];
      rf_data2 = rf[rf_read2];
   end

   typedef struct {
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  dest;
      logic        rw;
      logic [5:0]  alu;
      logic        ill;
   } exp_t;

   exp_t        q[$];
   bit          pend[int];
   int          cnt_m;
   int          n_cmp;
   int          n_bad;
   logic [31:0] pc_m;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void decode(input logic [31:0] i, output exp_t e,
                                  output bit us, output bit ut);
      int op, f_rs, f_rt, f_rd;
      op   = int'(i[31:26]);
      f_rs = int'(i[25:21]);
      f_rt = int'(i[20:16]);
      f_rd = int'(i[15:11]);
      e.rs_val = rf[f_rs];
      e.rt_val = rf[f_rt];
      e.pc   = '0;
      e.dest = 0;
      e.rw   = 0;
      e.ill  = 0;
      e.alu  = i[31:26];
      us = 0;
      ut = 0;
      if (op == 'h0c || op == 'h0d)
         e.imm = 32'(i[15:0]);
      else
         e.imm = 32'(signed'(i[15:0]));
      if (op == 0) begin
         e.dest = 5'(f_rd);
         e.rw   = (f_rd != 0);
         e.alu  = i[5:0];
         us = 1;
         ut = 1;
      end else if (op == 'h08 || op == 'h09 || op == 'h0c ||
                   op == 'h0d || op == 'h23) begin
         e.dest = 5'(f_rt);
         e.rw   = (f_rt != 0);
         us = 1;
      end else if (op == 'h2b || op == 'h04) begin
         us = 1;
         ut = 1;
      end else begin
         e.ill = 1;
      end
   endfunction

   // One clock of stimulus; the model advances at the rising edge.
   task automatic step(input bit v, input logic [31:0] instr, input bit ordy,
                       input bit wbv, input logic [4:0] wbr, output bit fire);
      exp_t e;
      bit   us, ut, hz, rdy;
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc_m;
      out_ready = ordy;
      wb_valid  = wbv;
      wb_reg    = wbr;
      @(negedge clk);
      decode(instr, e, us, ut);
      e.pc = pc_m;
      hz = v && ((us && pend.exists(int'(instr[25:21]))) ||
                 (ut && pend.exists(int'(instr[20:16]))) ||
                 (e.rw && pend.exists(int'(e.dest))));
      rdy = (q.size() == 0 || ordy) && !hz;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("rf_read1", 32'(rf_read1), 32'(instr[25:21]));
      chk("rf_read2", 32'(rf_read2), 32'(instr[20:16]));
      chk("stall_cnt", 32'(stall_cnt), 32'(cnt_m));
      fire = v && rdy;
      @(posedge clk);
      if (wbv)
         pend.delete(int'(wbr));
      if (fire && e.rw)
         pend[int'(e.dest)] = 1;
      if (fire) begin
         q.push_back(e);
         pc_m = pc_m + 4;
      end
      if (hz && cnt_m < 65535)
         cnt_m++;
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      wb_valid = 1'b1;
      wb_reg   = 5'd3;
      @(posedge clk);
      pend.delete();
      q.delete();
      cnt_m = 0;
      #1;
      rst      = 1'b0;
      wb_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("out_rs_val", out_rs_val, q[0].rs_val);
            chk("out_rt_val", out_rt_val, q[0].rt_val);
            chk("out_imm", out_imm, q[0].imm);
            chk("out_dest", 32'(out_dest), 32'(q[0].dest));
            chk("out_regwrite", 32'(out_regwrite), 32'(q[0].rw));
            chk("out_alu_op", 32'(out_alu_op), 32'(q[0].alu));
            chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
            chk("out_pc", out_pc, q[0].pc);
            if (out_ready)
               void'(q.pop_front());
         end
      end
   end

   function automatic logic [31:0] rnd_instr();
      logic [5:0] ops [11];
      logic [5:0] op;
      int k;
      ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0c,
              6'h0d, 6'h23, 6'h2b, 6'h04, 6'h3f};
      k  = $urandom_range(0, 11);
      op = (k == 11) ? 6'($urandom) : ops[k];
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          f;
      logic [31:0] cur;
      bit          have;
      int          keys[$];
      n_cmp = 0;
      n_bad = 0;
      cnt_m = 0;
      pc_m  = 32'h0000_1000;
      for (int i = 0; i < 32; i++)
         rf[i] = (i == 0) ? 32'h0 : $urandom;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      @(posedge clk);
      #1;
      do_reset();

      // ADD r3,r1,r2 then dependent ADD r4,r3,r1 stalls until wb r3
      step(1, 32'h0022_1820, 1, 0, 0, f);
      for (int i = 0; i < 3; i++)
         step(1, 32'h0061_2020, 1, 0, 0, f);
      step(1, 32'h0061_2020, 1, 1, 5'd3, f);
      step(1, 32'h0061_2020, 1, 0, 0, f);
      chk("dep_add_fired", 32'(f), 32'd1);
      step(0, 32'h0, 1, 1, 5'd4, f);

      // ORI / ADDI immediates
      step(1, 32'h3405_8000, 1, 0, 0, f);
      step(0, 32'h0, 1, 1, 5'd5, f);
      step(1, 32'h2005_8000, 1, 0, 0, f);
      step(0, 32'h0, 1, 1, 5'd5, f);

      // backpressure, then no-bubble handoff
      step(1, 32'h0022_3020, 0, 0, 0, f);
      step(1, 32'h0022_3820, 0, 0, 0, f);
      step(1, 32'h0022_3820, 0, 0, 0, f);
      step(1, 32'h0022_3820, 1, 1, 5'd6, f);
      chk("handoff_fired", 32'(f), 32'd1);
      step(0, 32'h0, 1, 1, 5'd7, f);

      // rd=0 write, illegal opcode, then a WAW-free reissue of r0 dest
      step(1, 32'h0022_0020, 1, 0, 0, f);
      step(1, 32'hFC00_0000, 1, 0, 0, f);
      step(1, 32'h0022_0020, 1, 0, 0, f);
      chk("r0_no_busy", 32'(f), 32'd1);

      // reset with r3 busy and output held
      step(1, 32'h0022_1820, 0, 0, 0, f);
      step(0, 32'h0, 0, 0, 0, f);
      do_reset();
      step(1, 32'h0061_2020, 1, 0, 0, f);
      chk("post_reset_issue", 32'(f), 32'd1);
      step(0, 32'h0, 1, 1, 5'd4, f);
      do_reset();

      have = 0;
      cur  = '0;
      for (int n = 0; n < 3000; n++) begin
         bit          v, ordy, wbv;
         logic [4:0]  wbr;
         if (!have) begin
            cur  = rnd_instr();
            have = ($urandom_range(0, 3) != 0);
         end
         v    = have;
         ordy = ($urandom_range(0, 3) != 0);
         wbv  = 0;
         wbr  = '0;
         keys.delete();
         foreach (pend[k])
            keys.push_back(k);
         if (keys.size() != 0 && $urandom_range(0, 2) == 0) begin
            wbv = 1;
            wbr = 5'(keys[$urandom_range(0, keys.size() - 1)]);
         end else if ($urandom_range(0, 9) == 0) begin
            wbv = 1;
            wbr = 5'($urandom_range(0, 7));
         end
         if (n == 1500) begin
            do_reset();
            have = 0;
         end else begin
            step(v, cur, ordy, wbv, wbr, f);
            if (f)
               have = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
